// File: rtl/uart_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_defs (package)
// Brief    : Shared UART constants, state encoding and clog2 helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_defs;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } uart_state_e;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : One-cycle tick every CLKS_PER_BIT clocks, restartable by clear.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int c_cnt_w = clog2(CLKS_PER_BIT);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    assign tick = (cnt_q == c_cnt_w'(CLKS_PER_BIT - 1));

    // clear aligns the count to the state-entry edge so every bit is exact
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : Multi-character UART transmitter with parity, stop and gap bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int NUM_BYTES    = 2,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NUM_BYTES*DATA_BITS-1:0] data,
    output logic                           tx,
    output logic                           busy,
    output logic                           done
);

    localparam int c_buf_w     = NUM_BYTES * DATA_BITS;
    localparam int c_idx_w     = clog2(NUM_BYTES) + 1;
    localparam int c_bit_max0  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int c_bit_max   = (c_bit_max0 > GAP_BITS) ? c_bit_max0 : GAP_BITS;
    localparam int c_bit_w     = clog2(c_bit_max);
    localparam int c_data_last = DATA_BITS - 1;
    localparam int c_stop_last = STOP_BITS - 1;
    localparam int c_gap_last  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
    localparam int c_char_last = NUM_BYTES - 1;

    uart_state_e          state_q, state_d;
    logic [c_bit_w-1:0]   bit_cnt_q, bit_cnt_d;
    logic [c_idx_w-1:0]   char_idx_q, char_idx_d;
    logic [c_buf_w-1:0]   buf_q, buf_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] cur_char;
    logic [DATA_BITS-1:0] char_shift;
    logic                 parity_bit;
    logic                 baud_clear;
    logic                 baud_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        char_idx_d = char_idx_q;
        buf_d      = buf_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_START;
                    buf_d      = data;
                    bit_cnt_d  = '0;
                    char_idx_d = '0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == c_bit_w'(c_data_last)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == c_bit_w'(c_stop_last)) begin
                        bit_cnt_d = '0;
                        if (char_idx_q == c_idx_w'(c_char_last)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            // Next character moves into the low slot of the buffer
                            char_idx_d = char_idx_q + 1'b1;
                            buf_d      = buf_q >> DATA_BITS;
                            state_d    = (GAP_BITS > 0) ? ST_GAP : ST_START;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == c_bit_w'(c_gap_last)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_START;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            done_d     = 1'b0;
            bit_cnt_d  = '0;
            char_idx_d = '0;
            buf_d      = '0;
        end

        // Line level is decoded from the next state so tx is a clean flop output
        cur_char   = buf_d[DATA_BITS-1:0];
        char_shift = cur_char >> bit_cnt_d;
        parity_bit = (PARITY == PARITY_ODD) ? ~(^cur_char) : ^cur_char;

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = char_shift[0];
            ST_PARITY: tx_d = parity_bit;
            default:   tx_d = 1'b1;
        endcase

        busy_d     = (state_d != ST_IDLE);
        baud_clear = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            char_idx_q <= '0;
            buf_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            char_idx_q <= char_idx_d;
            buf_q      <= buf_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Scoreboard bench for uart_tx_frame across several configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    localparam int CPB = 4;

    typedef struct {
        int    inst;
        string bits;      // expected line level per bit-time, earliest first
        int    ncycles;
        bit    exp_done;
        string name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_n4;
    logic [4:0]  start_v;
    logic [4:0]  abort_v;
    logic [15:0] data0;
    logic [7:0]  data1;
    logic [7:0]  data2;
    logic [13:0] data3;
    logic [15:0] data4;
    logic [4:0]  tx_w;
    logic [4:0]  busy_w;
    logic [4:0]  done_w;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt [5];
    exp_t sb [$];
    bit   mon_active = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .data(data0), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1), .PARITY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .data(data1), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1), .PARITY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .data(data2), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .NUM_BYTES(2),
                    .STOP_BITS(2), .GAP_BITS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .abort(abort_v[3]),
        .data(data3), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB)) u_dut4 (
        .clk(clk), .rst_n(rst_n4), .start(start_v[4]), .abort(abort_v[4]),
        .data(data4), .tx(tx_w[4]), .busy(busy_w[4]), .done(done_w[4]));

    initial begin
        for (int i = 0; i < 5; i++) done_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic push_frame(input int inst, input string bits, input string name);
        exp_t e;
        e.inst     = inst;
        e.bits     = bits;
        e.ncycles  = bits.len() * CPB;
        e.exp_done = 1'b1;
        e.name     = name;
        sb.push_back(e);
    endtask

    task automatic check_frame(input exp_t e);
        int   waited;
        int   bad;
        int   first_bad;
        logic exp_bit;
        waited    = 0;
        bad       = 0;
        first_bad = -1;
        @(negedge clk);
        while (tx_w[e.inst] !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            check({e.name, " start-bit timeout"}, 32'(waited), 32'd0);
            return;
        end
        for (int c = 0; c < e.ncycles; c++) begin
            if (c > 0) @(negedge clk);
            exp_bit = (e.bits[c / CPB] == "1");
            if (tx_w[e.inst] !== exp_bit || busy_w[e.inst] !== 1'b1 || done_w[e.inst] !== 1'b0) begin
                if (first_bad < 0) first_bad = c;
                bad++;
            end
        end
        check($sformatf("%s frame bad-cycles (first at %0d)", e.name, first_bad), 32'(bad), 32'd0);
        @(negedge clk);
        check({e.name, " end {tx,busy,done}"},
              {29'd0, tx_w[e.inst], busy_w[e.inst], done_w[e.inst]},
              e.exp_done ? 32'b101 : 32'b100);
    endtask

    initial begin
        exp_t cur;
        forever begin
            while (sb.size() == 0) @(negedge clk);
            mon_active = 1'b1;
            cur = sb.pop_front();
            check_frame(cur);
            mon_active = 1'b0;
        end
    end

    task automatic wait_sb_empty(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_active) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check({name, " scoreboard drain timeout"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_start(input int inst);
        @(posedge clk); #1 start_v[inst] = 1'b1;
        @(posedge clk); #1 start_v[inst] = 1'b0;
    endtask

    initial begin
        int d0;
        int n;
        int bad;
        rst_n   = 1'b0;
        rst_n4  = 1'b0;
        start_v = '0;
        abort_v = '0;
        data0   = '0;
        data1   = '0;
        data2   = '0;
        data3   = '0;
        data4   = '0;
        @(negedge clk);
        check("reset tx", 32'(tx_w), 32'h1f);
        check("reset busy/done", {22'd0, busy_w, done_w}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; rst_n4 = 1'b1;
        repeat (2) @(negedge clk);
        check("post-reset idle tx", 32'(tx_w), 32'h1f);

        // Two 8N1 characters, with stray start pulses and data changes mid-frame
        data0 = 16'hA53C;
        d0    = done_cnt[0];
        push_frame(0, "00011110010101001011", "8n1 A53C");
        pulse_start(0);
        data0 = 16'hFFFF;
        repeat (20) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        wait_sb_empty("8n1");
        repeat (3) @(negedge clk);
        check("8n1 done pulse count", 32'(done_cnt[0] - d0), 32'd1);

        data1 = 8'h07;
        push_frame(1, "01110000011", "even 07");
        pulse_start(1);
        wait_sb_empty("even");

        data2 = 8'h07;
        push_frame(2, "01110000001", "odd 07");
        pulse_start(2);
        wait_sb_empty("odd");

        data3 = {7'h0F, 7'h55};
        push_frame(3, "01010101111110111100011", "7d2s gap3");
        pulse_start(3);
        wait_sb_empty("gap");

        // start held high across two transactions
        data0 = 16'h8001;
        push_frame(0, "01000000010000000011", "b2b first");
        push_frame(0, "01111111110000000001", "b2b second");
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 data0 = 16'h00FF;
        n = 0;
        @(negedge clk);
        while (done_w[0] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("b2b first done seen", 32'(n < 500), 32'd1);
        @(posedge clk); #1 start_v[0] = 1'b0;
        @(negedge clk);
        check("b2b one idle cycle then start bit", {30'd0, tx_w[0], busy_w[0]}, 32'b01);
        wait_sb_empty("b2b");

        // abort during the third data bit of character 0
        begin
            exp_t e;
            e.inst = 0; e.bits = "0001"; e.ncycles = 14; e.exp_done = 1'b0; e.name = "abort";
            sb.push_back(e);
        end
        data0 = 16'hA53C;
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (13) @(posedge clk);
        #1 abort_v[0] = 1'b1;
        @(posedge clk); #1 abort_v[0] = 1'b0;
        d0 = done_cnt[0];
        repeat (10) @(negedge clk);
        check("abort no done", 32'(done_cnt[0] - d0), 32'd0);
        wait_sb_empty("abort");

        // abort and start together in IDLE: start wins
        data0 = 16'h5AC3;
        push_frame(0, "01100001110010110101", "after abort 5AC3");
        @(posedge clk); #1 start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0; abort_v[0] = 1'b0;
        wait_sb_empty("after abort");

        // asynchronous reset in the middle of the data bits
        data4 = 16'hA53C;
        @(posedge clk); #1 start_v[4] = 1'b1;
        @(posedge clk); #1 start_v[4] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre-reset busy", 32'(busy_w[4]), 32'd1);
        #1 rst_n4 = 1'b0;
        #1;
        check("async reset {tx,busy,done}", {29'd0, tx_w[4], busy_w[4], done_w[4]}, 32'b100);
        @(posedge clk); #3 rst_n4 = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_w[4] !== 1'b1 || busy_w[4] !== 1'b0) bad++;
        end
        check("post-reset idle cycles bad", 32'(bad), 32'd0);
        push_frame(4, "00011110010101001011", "after reset A53C");
        pulse_start(4);
        wait_sb_empty("after reset");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, actual=%0d checks required=completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
